mult_operand_issuer: RTL

Operand sequencer that feeds the limb multipliers (`multiplier_upper_2_bit`, `multiplier_middle_bit`). It collects two wide operands as streams of LIMB_W-bit limbs and buffers them. After a `start` command, it drives every limb pair (A[i], B[j]) onto the multiplier operand bus, with a single-cycle `en` pulse and the pair's limb indices. It is the producer end of the multiplier's `en`/operand interface and sits between the operand loader and the multiplier/accumulator array.

---
 rtl/mult_operand_issuer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mult_operand_issuer.sv
// Operand sequencer for the limb multipliers: buffers two NUM_LIMBS-limb operands,
// then issues every (A[i], B[j]) pair i-major with an en pulse every ISSUE_GAP cycles.
module mult_operand_issuer #(
    parameter int LIMB_W    = 110,
    parameter int NUM_LIMBS = 4,
    parameter int ISSUE_GAP = 4,
    parameter int IDX_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LIMB_W-1:0] in_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              en,
    output logic [LIMB_W-1:0] a_limb,
    output logic [LIMB_W-1:0] b_limb,
    output logic [IDX_W-1:0]  a_idx,
    output logic [IDX_W-1:0]  b_idx,
    output logic              last
);

    localparam int LCNT_W = $clog2(2 * NUM_LIMBS);
    localparam int GAP_W  = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [LCNT_W-1:0] LOAD_LAST = LCNT_W'(2 * NUM_LIMBS - 1);
    localparam logic [LCNT_W-1:0] LOAD_B    = LCNT_W'(NUM_LIMBS);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_LIMBS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(ISSUE_GAP - 1);

    typedef enum logic [1:0] {S_LOAD, S_READY, S_ISSUE} state_t;

    state_t             state;
    logic [LCNT_W-1:0]  load_cnt;
    logic [IDX_W-1:0]   i_cnt;
    logic [IDX_W-1:0]   j_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               issued_all;
    logic [LIMB_W-1:0]  a_buf [NUM_LIMBS];
    logic [LIMB_W-1:0]  b_buf [NUM_LIMBS];

    logic               load_is_b;
    logic [LCNT_W-1:0]  b_off;
    logic [IDX_W-1:0]   wr_idx;
    logic               pair_is_last;

    assign in_ready     = (state == S_LOAD);
    assign busy         = (state == S_ISSUE);
    assign load_is_b    = (load_cnt >= LOAD_B);
    assign b_off        = load_cnt - LOAD_B;
    assign wr_idx       = load_is_b ? IDX_W'(b_off) : IDX_W'(load_cnt);
    assign pair_is_last = (i_cnt == IDX_LAST) && (j_cnt == IDX_LAST);

    // The pair after the final issue is never driven; issued_all makes the next
    // gap-zero slot the done slot, so the last pair still gets a full gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOAD;
            load_cnt   <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            gap_cnt    <= '0;
            issued_all <= 1'b0;
            en         <= 1'b0;
            done       <= 1'b0;
            last       <= 1'b0;
            a_limb     <= '0;
            b_limb     <= '0;
            a_idx      <= '0;
            b_idx      <= '0;
            for (int k = 0; k < NUM_LIMBS; k++) begin
                a_buf[k] <= '0;
                b_buf[k] <= '0;
            end
        end else begin
            en   <= 1'b0;
            done <= 1'b0;
            last <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (load_is_b) b_buf[wr_idx] <= in_data;
                        else           a_buf[wr_idx] <= in_data;
                        if (load_cnt == LOAD_LAST) begin
                            load_cnt <= '0;
                            state    <= S_READY;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (start) begin
                        state      <= S_ISSUE;
                        i_cnt      <= '0;
                        j_cnt      <= '0;
                        gap_cnt    <= '0;
                        issued_all <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
                    if (gap_cnt == '0) begin
                        if (issued_all) begin
                            done     <= 1'b1;
                            state    <= S_LOAD;
                            load_cnt <= '0;
                        end else begin
                            en         <= 1'b1;
                            a_limb     <= a_buf[i_cnt];
                            b_limb     <= b_buf[j_cnt];
                            a_idx      <= i_cnt;
                            b_idx      <= j_cnt;
                            last       <= pair_is_last;
                            issued_all <= pair_is_last;
                            if (j_cnt == IDX_LAST) begin
                                j_cnt <= '0;
                                i_cnt <= (i_cnt == IDX_LAST) ? '0 : i_cnt + 1'b1;
                            end else begin
                                j_cnt <= j_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
